// File: rtl/flash_req_arbiter.sv
// flash_req_arbiter: round-robin arbiter for two requesters
// sharing one APB port to a SPI flash controller.
module flash_req_arbiter #(
  parameter int APBBITWIDE  = 32,
  parameter int WAIT_CYCLES = 40
) (
  input  logic                  p_clk,
  input  logic                  p_rst_n,
  input  logic                  r0_req,
  input  logic                  r0_write,
  input  logic [APBBITWIDE-1:0] r0_addr,
  input  logic [APBBITWIDE-1:0] r0_wdata,
  output logic                  r0_ack,
  output logic [APBBITWIDE-1:0] r0_rdata,
  input  logic                  r1_req,
  input  logic                  r1_write,
  input  logic [APBBITWIDE-1:0] r1_addr,
  input  logic [APBBITWIDE-1:0] r1_wdata,
  output logic                  r1_ack,
  output logic [APBBITWIDE-1:0] r1_rdata,
  output logic [APBBITWIDE-1:0] m_addr,
  output logic                  m_write,
  output logic                  m_sel_x,
  output logic                  m_enable,
  output logic [APBBITWIDE-1:0] m_wdata,
  input  logic [APBBITWIDE-1:0] m_rdata,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_WAIT,
    S_DONE
  } state_e;

  localparam logic [7:0] CNT_LOAD = 8'(WAIT_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    ptr_q, ptr_d;
  logic                    gnt_q, gnt_d;
  logic                    wr_q, wr_d;
  logic [APBBITWIDE-1:0]   addr_q, addr_d;
  logic [APBBITWIDE-1:0]   wdata_q, wdata_d;
  logic [APBBITWIDE-1:0]   rdata0_q, rdata0_d;
  logic [APBBITWIDE-1:0]   rdata1_q, rdata1_d;
  logic                    sel_q, sel_d;
  logic                    en_q, en_d;
  logic                    ack0_q, ack0_d;
  logic                    ack1_q, ack1_d;
  logic                    busy_q, busy_d;
  logic                    win;

  // Next state, arbitration, latching and registered-output decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    win      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (r0_req | r1_req) begin
          win     = (r0_req & r1_req) ? ~ptr_q : r1_req;
          gnt_d   = win;
          ptr_d   = win;
          wr_d    = win ? r1_write : r0_write;
          addr_d  = win ? r1_addr  : r0_addr;
          wdata_d = win ? r1_wdata : r0_wdata;
          state_d = S_SETUP;
        end
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        state_d = S_WAIT;
        cnt_d   = CNT_LOAD;
      end
      S_WAIT: begin
        if (cnt_q == 8'd0) state_d = S_DONE;
        else cnt_d = cnt_q - 8'd1;
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (!wr_q) begin
          if (gnt_q) rdata1_d = m_rdata;
          else rdata0_d = m_rdata;
        end
      end
      default: state_d = S_IDLE;
    endcase
    sel_d  = (state_d == S_SETUP) || (state_d == S_ACCESS);
    en_d   = (state_d == S_ACCESS);
    busy_d = (state_d != S_IDLE);
    ack0_d = (state_d == S_DONE) && !gnt_d;
    ack1_d = (state_d == S_DONE) && gnt_d;
  end

  // State and output registers; pointer resets to 1 so r0 wins the first tie.
  always_ff @(posedge p_clk or negedge p_rst_n) begin
    if (!p_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ptr_q    <= 1'b1;
      gnt_q    <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      sel_q    <= 1'b0;
      en_q     <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      sel_q    <= sel_d;
      en_q     <= en_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      busy_q   <= busy_d;
    end
  end

  assign m_addr   = addr_q;
  assign m_write  = wr_q;
  assign m_wdata  = wdata_q;
  assign m_sel_x  = sel_q;
  assign m_enable = en_q;
  assign r0_ack   = ack0_q;
  assign r1_ack   = ack1_q;
  assign r0_rdata = rdata0_q;
  assign r1_rdata = rdata1_q;
  assign busy     = busy_q;

endmodule

// File: doc/flash_req_arbiter.md
FLASH_REQ_ARBITER -- requirements
Module: flash_req_arbiter

Interface
REQ-001 Parameter APBBITWIDE, default 32: address and data width.
REQ-002 Parameter WAIT_CYCLES, default 40: cycles allowed for the downstream flash controller to finish its SPI transaction. Legal range is 1..255.
REQ-003 p_clk  in  1  single clock; all state changes on the rising edge.
REQ-004 p_rst_n  in  1  asynchronous active-low reset.
REQ-005 r0_req  in  1  requester 0 transfer request; held high until r0_ack.
REQ-006 r0_write  in  1  requester 0 direction: 1 = write, 0 = read.
REQ-007 r0_addr  in  APBBITWIDE  requester 0 flash address.
REQ-008 r0_wdata  in  APBBITWIDE  requester 0 write data.
REQ-009 r0_ack  out  1  one-cycle completion pulse to requester 0.
REQ-010 r0_rdata  out  APBBITWIDE  requester 0 read data.
REQ-011 r1_req, r1_write, r1_addr, r1_wdata, r1_ack, r1_rdata: same directions, widths and meanings as REQ-005..010, for requester 1.
REQ-012 m_addr  out  APBBITWIDE  APB address to the flash controller.
REQ-013 m_write  out  1  APB write strobe.
REQ-014 m_sel_x  out  1  APB select.
REQ-015 m_enable  out  1  APB enable.
REQ-016 m_wdata  out  APBBITWIDE  APB write data.
REQ-017 m_rdata  in  APBBITWIDE  APB read data from the controller.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, SETUP, ACCESS, WAIT and DONE. Transitions:
- IDLE -> SETUP when any req is high.
- SETUP -> ACCESS unconditionally.
- ACCESS -> WAIT unconditionally.
- WAIT -> DONE when the counter reaches 0.
- DONE -> IDLE unconditionally.
REQ-020 Arbitration in IDLE SHALL be round-robin with a one-bit last-served pointer:
- Only one req high: that requester wins.
- Both high: the requester not equal to the pointer wins.
- The pointer updates to the winner on the grant edge.
REQ-021 On the grant edge, the winner's addr/write/wdata SHALL be latched. Later changes on requester inputs SHALL NOT affect the transfer in flight.
REQ-022 SETUP: m_sel_x=1, m_enable=0, and m_addr/m_write/m_wdata driven from the latched values.
REQ-023 ACCESS: m_sel_x=1 and m_enable=1 for exactly one cycle, with the same latched values.
REQ-024 WAIT: m_sel_x=0 and m_enable=0; m_addr/m_write/m_wdata hold.
- An 8-bit down-counter loads WAIT_CYCLES-1 on entry and decrements each cycle.
- WAIT lasts exactly WAIT_CYCLES cycles.
REQ-025 DONE: the granted requester's ack SHALL be 1 for exactly one cycle.
- Read: that requester's rdata captures m_rdata on the DONE->IDLE edge and holds until its next read completes.
- Write: rdata is unchanged.
- The non-granted ack SHALL stay 0.
REQ-026 Latency: if req is first sampled in IDLE at edge E0, the ack cycle SHALL begin at edge E0+2+WAIT_CYCLES.
REQ-027 The requester SHALL deassert req on the edge at which ack=1 is sampled. A req high in IDLE is always treated as a new request.
REQ-028 A req that rises while another transfer is in progress SHALL wait, with no loss, and is arbitrated in the next IDLE.
REQ-029 Back-to-back: IDLE SHALL last at least one cycle between transfers. With both requesters continuously requesting, grants SHALL strictly alternate.
REQ-030 A req that deasserts before its grant SHALL be ignored. A req that deasserts after grant SHALL NOT abort the transfer; the ack is still issued.

Reset
REQ-031 While p_rst_n=0, the block SHALL immediately and asynchronously enter IDLE with:
- all outputs 0, including r0_rdata/r1_rdata;
- counter 0;
- pointer = 1, so r0 wins the first tie.
REQ-032 Reset asserted mid-transfer SHALL abandon the transfer with no ack issued. The first grant after release SHALL occur no earlier than the first rising edge with p_rst_n=1.

Verification
REQ-033 The bench SHALL cover these scenarios (WAIT_CYCLES=4 unless stated):
- r0 write, addr 0, wdata 0xFF00FF00 -> SETUP sel=1/en=0, ACCESS sel=1/en=1 with m_wdata=0xFF00FF00 and m_write=1, 4 WAIT cycles, r0_ack pulse at E0+6, r0_rdata still 0.
- r1 read, addr 0, model returns 0xFF00FF00 -> m_write=0 in SETUP and ACCESS, r1_rdata=0xFF00FF00 after the ack, r0_rdata unchanged.
- r0 and r1 both raised in the same cycle after reset, each re-requesting after its ack -> grant order r0, r1, r0, r1; one ack per transfer; acks never overlap.
- r1 raised during r0's WAIT -> r1 granted in the IDLE cycle after r0's DONE, with no gap beyond one IDLE cycle.
- p_rst_n pulsed low during WAIT -> all outputs 0 asynchronously, no ack, busy=0; a new r0 request then completes normally.
- WAIT_CYCLES=1 -> ack at E0+3; m_enable high exactly one cycle.
